icache: RTL

Direct-mapped, read-only instruction cache between the instruction fetcher and the memory controller. Serves fetcher word requests from a local array in one cycle on a hit. On a miss it issues a single 32-bit fetch to the memory controller's fetcher port, fills the line, and forwards the word. It also supports fetcher rollback on branch mispredict, so a stale miss fills the cache but is never delivered.

---
 rtl/icache.sv | 127 ++++++++++++
 1 files changed

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache: one 32-bit word per line, single-cycle hits,
// one outstanding memory fetch per miss, and rollback that lets a stale fill land undelivered.
module icache #(
    parameter int INDEX_BITS = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        in_fetch_ena,
    input  logic [31:0] in_fetch_addr,
    input  logic        in_rollback,
    output logic        out_fetch_ok,
    output logic [31:0] out_fetch_data,
    output logic        out_mem_ena,
    output logic [31:0] out_mem_addr,
    input  logic        in_mem_ok,
    input  logic [31:0] in_mem_data
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t            state_q, state_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [31:0]       pend_addr_q, pend_addr_d;
    logic              drop_q, drop_d;
    logic              fetch_ok_q, fetch_ok_d;
    logic [31:0]       fetch_data_q, fetch_data_d;
    logic              mem_ena_q, mem_ena_d;
    logic [31:0]       mem_addr_q, mem_addr_d;

    logic [31:0]       data_mem [LINES];
    logic [TAG_W-1:0]  tag_mem  [LINES];

    logic [INDEX_BITS-1:0] req_idx, pend_idx;
    logic [TAG_W-1:0]      req_tag, pend_tag;
    logic                  hit, accept, fill;
    logic                  unused_bits;

    assign req_idx  = in_fetch_addr[INDEX_BITS+1:2];
    assign req_tag  = in_fetch_addr[31:INDEX_BITS+2];
    assign pend_idx = pend_addr_q[INDEX_BITS+1:2];
    assign pend_tag = pend_addr_q[31:INDEX_BITS+2];
    assign unused_bits = ^{in_fetch_addr[1:0], pend_addr_q[1:0]};

    assign hit    = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    // A live out_fetch_ok blocks acceptance so a still-held request is not served twice.
    assign accept = ena && in_fetch_ena && !in_rollback && !fetch_ok_q && (state_q == IDLE);
    assign fill   = ena && in_mem_ok && (state_q == WAIT_MEM);

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        pend_addr_d  = pend_addr_q;
        drop_d       = drop_q;
        fetch_ok_d   = 1'b0;
        fetch_data_d = fetch_data_q;
        mem_ena_d    = 1'b0;
        mem_addr_d   = mem_addr_q;
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            fetch_ok_d   = 1'b1;
                            fetch_data_d = data_mem[req_idx];
                        end else begin
                            mem_ena_d   = 1'b1;
                            mem_addr_d  = {in_fetch_addr[31:2], 2'b00};
                            pend_addr_d = in_fetch_addr;
                            drop_d      = 1'b0;
                            state_d     = WAIT_MEM;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (in_rollback) drop_d = 1'b1;
                    if (in_mem_ok) begin
                        valid_d[pend_idx] = 1'b1;
                        if (!drop_q && !in_rollback) begin
                            fetch_ok_d   = 1'b1;
                            fetch_data_d = in_mem_data;
                        end
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            pend_addr_q  <= '0;
            drop_q       <= 1'b0;
            fetch_ok_q   <= 1'b0;
            fetch_data_q <= '0;
            mem_ena_q    <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            pend_addr_q  <= pend_addr_d;
            drop_q       <= drop_d;
            fetch_ok_q   <= fetch_ok_d;
            fetch_data_q <= fetch_data_d;
            mem_ena_q    <= mem_ena_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    // Data and tags need no reset; the valid vector alone qualifies them.
    always_ff @(posedge clk) begin
        if (fill) begin
            data_mem[pend_idx] <= in_mem_data;
            tag_mem[pend_idx]  <= pend_tag;
        end
    end

    assign out_fetch_ok   = fetch_ok_q;
    assign out_fetch_data = fetch_data_q;
    assign out_mem_ena    = mem_ena_q;
    assign out_mem_addr   = mem_addr_q;
endmodule
